// File: rtl/sram_pkg.sv
// Shared definitions for the word-to-halfword SRAM port.
//   state_t        : access sequencer states
//   SRAM_BASE_ADDR : CPU byte address that maps to SRAM word 0
//   SRAM_AW/DW     : off-chip SRAM address and data widths (256K x 16)
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
  localparam int          SRAM_AW        = 18;
  localparam int          SRAM_DW        = 16;

endpackage

// File: rtl/sram_word_port.sv
// Converts one 32-bit word read/write request from the data-cache controller into
// two 16-bit accesses (low halfword, then high halfword) on a 256K x 16 SRAM.
// Each half-access holds address/data for WAIT_CYCLES cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wr_en, rd_en      word request levels, held by the caller until done
//   address           CPU byte address (BASE_ADDR maps to SRAM word 0)
//   write_data        word to write
//   read_data         last word read, updated as done rises
//   done              one-cycle completion pulse
//   SRAM_*            off-chip SRAM pins (DQ bidirectional)
module sram_word_port
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               done,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam int                CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 op_wr;
  logic [SRAM_AW-2:0]   idx;
  logic [SRAM_AW-2:0]   idx_nxt;
  logic [31:0]          wdata;
  logic [SRAM_DW-1:0]   lo_q;
  logic                 active;
  logic                 half_last;
  logic                 accept;
  logic                 dq_en;
  logic [SRAM_DW-1:0]   dq_out;

  // Word index: byte offset from the base, bits [1:0] dropped, anything above
  // the SRAM word range truncated so out-of-range addresses wrap.
  assign idx_nxt   = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  assign active    = (state == LO) || (state == HI);
  assign half_last = (cnt == CNT_LAST);
  assign accept    = (state == IDLE) && (wr_en || rd_en);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wr_en || rd_en) state_nxt = LO;
      LO:      if (half_last)      state_nxt = HI;
      HI:      if (half_last)      state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      idx       <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        op_wr <= wr_en;   // write wins when both requests are high
        idx   <= idx_nxt;
      end
      // High half is sampled on the last HI edge; the word becomes visible as DONE starts.
      if ((state == HI) && half_last && !op_wr) begin
        read_data <= {SRAM_DQ, lo_q};
      end
    end
  end

  // Pure data holding registers; their content is qualified by state.
  always_ff @(posedge clk) begin
    if (accept && wr_en) begin
      wdata <= write_data;
    end
    if ((state == LO) && half_last) begin
      lo_q <= SRAM_DQ;
    end
  end

  assign done      = (state == DONE);
  assign SRAM_ADDR = {idx, (state == HI)};
  assign SRAM_OE_N = ~(active && !op_wr);
  // WE_N rises one cycle before the half ends so address and data are held past the write strobe.
  assign SRAM_WE_N = ~(active && op_wr && !half_last);
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign dq_en   = active && op_wr;
  assign dq_out  = (state == HI) ? wdata[31:16] : wdata[15:0];
  assign SRAM_DQ = dq_en ? dq_out : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_word_port.sv
module tb_sram_word_port;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Instance 0: default WAIT_CYCLES=2; instance 1: WAIT_CYCLES=4.
  logic        wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  logic [31:0] ad0 = 0, wd0 = 0, ad1 = 0, wd1 = 0;
  logic [31:0] rdat0, rdat1;
  logic        done0, done1;
  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        ub0, lb0, ce0, oe0, we0, ub1, lb1, ce1, oe1, we1;

  sram_word_port dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(ad0), .write_data(wd0),
    .read_data(rdat0), .done(done0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0)
  );

  sram_word_port #(.WAIT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(ad1), .write_data(wd1),
    .read_data(rdat1), .done(done1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural 256K x 16 SRAMs: drive DQ while reading, latch on WE_N rising,
  // and check that address and data are still held at that rising edge.
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  logic [17:0] we_addr0, we_addr1;

  assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 16'hzzzz;
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 16'hzzzz;

  always @(negedge we0) we_addr0 <= sa0;
  always @(negedge we1) we_addr1 <= sa1;
  always @(posedge we0) if (armed) begin
    chk("we0_addr_hold", 32'(sa0), 32'(we_addr0));
    chk("we0_dq_driven", 32'(dut0.dq_en), 32'd1);
    mem0[sa0] <= dq0;
  end
  always @(posedge we1) if (armed) begin
    chk("we1_addr_hold", 32'(sa1), 32'(we_addr1));
    chk("we1_dq_driven", 32'(dut1.dq_en), 32'd1);
    mem1[sa1] <= dq1;
  end

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;   // read_data after the op (unchanged for writes)
    logic [17:0] exp_sa;      // SRAM address of the low half
  } vec_t;

  // Applies one request to instance s and checks the whole access.
  // Sample n (taken mid-cycle) lies in cycle k+n-1 for acceptance at edge k,
  // so done in cycle k+2W appears at sample 2W+1.
  task automatic apply_vec(input int s, input vec_t v, input int w);
    int          lat = 0, oe_c = 0, we_c = 0;
    logic [17:0] a_first = '0, a_last = '0;
    logic        dq_in_done = 1'b0;
    bit          timeout = 1'b1;
    string       tag;
    tag = $sformatf("i%0d_%s@%h", s, v.wr ? "wr" : "rd", v.addr);
    @(negedge clk);
    if (s == 0) begin wr0 = v.wr; rd0 = v.rd; ad0 = v.addr; wd0 = v.wdata; end
    else        begin wr1 = v.wr; rd1 = v.rd; ad1 = v.addr; wd1 = v.wdata; end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if ((s == 0) ? done0 : done1) begin
        lat        = i;
        timeout    = 1'b0;
        dq_in_done = (s == 0) ? dut0.dq_en : dut1.dq_en;
        if (s == 0) begin wr0 = 0; rd0 = 0; end else begin wr1 = 0; rd1 = 0; end
        break;
      end
      a_last = (s == 0) ? sa0 : sa1;
      if (i == 1) a_first = a_last;
      if (((s == 0) ? oe0 : oe1) == 1'b0) oe_c++;
      if (((s == 0) ? we0 : we1) == 1'b0) we_c++;
    end
    if (timeout) begin
      if (s == 0) begin wr0 = 0; rd0 = 0; end else begin wr1 = 0; rd1 = 0; end
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_latency"},   32'(lat),     32'(2 * w + 1));
    chk({tag, "_addr_lo"},   32'(a_first), 32'(v.exp_sa));
    chk({tag, "_addr_hi"},   32'(a_last),  32'(v.exp_sa | 18'd1));
    chk({tag, "_oe_cycles"}, 32'(oe_c),    v.wr ? 32'd0 : 32'(2 * w));
    chk({tag, "_we_cycles"}, 32'(we_c),    v.wr ? 32'(2 * (w - 1)) : 32'd0);
    chk({tag, "_read_data"}, (s == 0) ? rdat0 : rdat1, v.exp_rdata);
    chk({tag, "_dq_z_done"}, 32'(dq_in_done), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'((s == 0) ? done0 : done1), 32'd0);
    chk({tag, "_dq_z_idle"},  32'((s == 0) ? dut0.dq_en : dut1.dq_en), 32'd0);
    if (v.wr) begin
      chk({tag, "_mem_lo"}, 32'((s == 0) ? mem0[v.exp_sa] : mem1[v.exp_sa]), 32'(v.wdata[15:0]));
      chk({tag, "_mem_hi"}, 32'((s == 0) ? mem0[v.exp_sa | 18'd1] : mem1[v.exp_sa | 18'd1]),
          32'(v.wdata[31:16]));
    end
  endtask

  vec_t vecs0 [11];
  vec_t vecs1 [4];
  vec_t rv;

  initial begin
    vecs0[0]  = '{1, 0, 32'd1024,            32'hDEADBEEF, 32'h00000000, 18'h00000};
    vecs0[1]  = '{0, 1, 32'd1024,            32'h0,        32'hDEADBEEF, 18'h00000};
    vecs0[2]  = '{1, 0, 32'd1028,            32'h12345678, 32'hDEADBEEF, 18'h00002};
    vecs0[3]  = '{0, 1, 32'd1028,            32'h0,        32'h12345678, 18'h00002};
    vecs0[4]  = '{1, 0, 32'd1024 + 32'h7FFFC, 32'hA5A55A5A, 32'h12345678, 18'h3FFFE};
    vecs0[5]  = '{0, 1, 32'd1024 + 32'h80000, 32'h0,        32'hDEADBEEF, 18'h00000};
    vecs0[6]  = '{0, 1, 32'd1024 + 32'h7FFFC, 32'h0,        32'hA5A55A5A, 18'h3FFFE};
    vecs0[7]  = '{0, 1, 32'd1026,            32'h0,        32'hDEADBEEF, 18'h00000};
    vecs0[8]  = '{1, 0, 32'd1024 + 32'h100,  32'h0000FFFF, 32'hDEADBEEF, 18'h00080};
    vecs0[9]  = '{1, 1, 32'd1032,            32'hCAFEF00D, 32'hDEADBEEF, 18'h00004};
    vecs0[10] = '{0, 1, 32'd1032,            32'h0,        32'hCAFEF00D, 18'h00004};

    vecs1[0]  = '{1, 0, 32'd1024 + 32'h7FFFC, 32'h11223344, 32'h00000000, 18'h3FFFE};
    vecs1[1]  = '{1, 0, 32'd1024 + 32'h80000, 32'h55667788, 32'h00000000, 18'h00000};
    vecs1[2]  = '{0, 1, 32'd1024,            32'h0,        32'h55667788, 18'h00000};
    vecs1[3]  = '{0, 1, 32'd1024 + 32'h7FFFC, 32'h0,        32'h11223344, 18'h3FFFE};

    // Reset state
    @(negedge clk);
    chk("rst_state",     32'(dut0.state), 32'(IDLE));
    chk("rst_done",      32'(done0), 32'd0);
    chk("rst_read_data", rdat0,      32'd0);
    chk("rst_oe_n",      32'(oe0),   32'd1);
    chk("rst_we_n",      32'(we0),   32'd1);
    chk("rst_sram_addr", 32'(sa0),   32'd0);
    chk("rst_dq_z",      32'(dut0.dq_en), 32'd0);
    chk("rst_tied_en",   32'({ub0, lb0, ce0}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    armed = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(0, vecs0[i], 2);

    // Reset asserted in the second HI cycle of a read aborts it at once.
    @(negedge clk);
    rd0 = 1'b1; ad0 = 32'd1028;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state",     32'(dut0.state), 32'(IDLE));
    chk("abort_done",      32'(done0), 32'd0);
    chk("abort_read_data", rdat0,      32'd0);
    chk("abort_oe_n",      32'(oe0),   32'd1);
    chk("abort_sram_addr", 32'(sa0),   32'd0);
    chk("abort_dq_z",      32'(dut0.dq_en), 32'd0);
    rd0 = 1'b0;
    rst = 1'b0;
    rv = '{0, 1, 32'd1028, 32'h0, 32'h12345678, 18'h00002};
    apply_vec(0, rv, 2);

    for (int i = 0; i < 4; i++) apply_vec(1, vecs1[i], 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
